pll_lock_sequencer: RTL and testbench



---
 rtl/pll_lock_sequencer_pkg.sv | 22 ++
 rtl/pll_lock_sequencer_bit_synchronizer.sv | 23 ++
 rtl/pll_lock_sequencer.sv | 112 +++++++++++
 tb/tb_pll_lock_sequencer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_lock_sequencer_pkg.sv
// Shared types and sizing helpers for the PLL lock sequencer and its synchronizer.
package pll_lock_sequencer_pkg;

    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } seq_state_e;

    // Timer must hold 0 .. max(a,b,c)-1; never narrower than one bit.
    function automatic int unsigned timer_width(input int unsigned a,
                                                input int unsigned b,
                                                input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/pll_lock_sequencer_bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous level signal.
module bit_synchronizer #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock supervisor: pulses the PLL reset, qualifies lock stability,
// recovers from lock loss or lock timeout, and keeps saturating health counters.
module pll_lock_sequencer
    import pll_lock_sequencer_pkg::*;
#(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 50000,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             locked,
    output logic             pll_rst,
    output logic             pll_ready,
    output logic             lock_lost,
    output logic [CNT_W-1:0] relock_count,
    output logic [CNT_W-1:0] timeout_count
);

    localparam int unsigned TW = timer_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam logic [TW-1:0] RST_LAST    = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] STABLE_LAST = TW'(STABLE_CYCLES - 1);

    seq_state_e       state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             pll_rst_q, pll_rst_d;
    logic             pll_ready_q, pll_ready_d;
    logic             lock_lost_q, lock_lost_d;
    logic [CNT_W-1:0] relock_q, relock_d;
    logic [CNT_W-1:0] timeout_q, timeout_d;
    logic             lk_s;

    bit_synchronizer #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_lock_sync (
        .clk_i  (refclk),
        .rst_n_i(rst_n),
        .d_i    (locked),
        .q_o    (lk_s)
    );

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= PLL_RST;
            timer_q     <= '0;
            pll_rst_q   <= 1'b1;
            pll_ready_q <= 1'b0;
            lock_lost_q <= 1'b0;
            relock_q    <= '0;
            timeout_q   <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            pll_rst_q   <= pll_rst_d;
            pll_ready_q <= pll_ready_d;
            lock_lost_q <= lock_lost_d;
            relock_q    <= relock_d;
            timeout_q   <= timeout_d;
        end
    end

    // The shared timer counts cycles spent in the current state and clears on every entry.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q + TW'(1);
        lock_lost_d = 1'b0;
        relock_d    = relock_q;
        timeout_d   = timeout_q;
        case (state_q)
            PLL_RST: begin
                if (timer_q == RST_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lk_s) begin
                    state_d = STABLE;
                end else if (timer_q == TIMEOUT_LAST) begin
                    state_d = PLL_RST;
                    if (timeout_q != {CNT_W{1'b1}}) timeout_d = timeout_q + CNT_W'(1);
                end
            end
            STABLE: begin
                if (!lk_s) begin
                    state_d = WAIT_LOCK;
                end else if (timer_q == STABLE_LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!lk_s) begin
                    state_d     = PLL_RST;
                    lock_lost_d = 1'b1;
                    if (relock_q != {CNT_W{1'b1}}) relock_d = relock_q + CNT_W'(1);
                end
            end
            default: state_d = PLL_RST;
        endcase
        if (state_d != state_q) timer_d = '0;
        // Outputs are registered from the next state so they change cleanly on the edge.
        pll_rst_d   = (state_d == PLL_RST);
        pll_ready_d = (state_d == RUN);
    end

    assign pll_rst       = pll_rst_q;
    assign pll_ready     = pll_ready_q;
    assign lock_lost     = lock_lost_q;
    assign relock_count  = relock_q;
    assign timeout_count = timeout_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer: directed scenarios plus random
// lock stimulus compared against a behavioural model.
module tb_pll_lock_sequencer;

    localparam int R  = 4;
    localparam int T  = 20;
    localparam int S  = 8;
    localparam int SS = 2;
    localparam int CW = 8;

    logic          refclk = 1'b0;
    logic          rst_n  = 1'b1;
    logic          locked = 1'b0;
    logic          pll_rst, pll_ready, lock_lost;
    logic [CW-1:0] relock_count, timeout_count;

    int errors = 0;
    int checks = 0;

    always #10 refclk = ~refclk;

    pll_lock_sequencer #(
        .RST_CYCLES   (R),
        .LOCK_TIMEOUT (T),
        .STABLE_CYCLES(S),
        .SYNC_STAGES  (SS),
        .CNT_W        (CW)
    ) dut (
        .refclk       (refclk),
        .rst_n        (rst_n),
        .locked       (locked),
        .pll_rst      (pll_rst),
        .pll_ready    (pll_ready),
        .lock_lost    (lock_lost),
        .relock_count (relock_count),
        .timeout_count(timeout_count)
    );

    // Behavioural model: remaining reset-pulse cycles, cycles waited for lock,
    // length of the current good-lock streak, and a RUN flag.
    int       m_rst_left, m_wait, m_streak, m_to, m_rl;
    bit       m_run, m_lost;
    bit [SS-1:0] m_sync;

    always @(posedge refclk or negedge rst_n) begin : model
        bit lk;
        if (!rst_n) begin
            m_rst_left = R; m_wait = 0; m_streak = 0; m_run = 0;
            m_lost = 0; m_to = 0; m_rl = 0; m_sync = '0;
        end else begin
            lk = m_sync[SS-1];
            m_lost = 0;
            if (m_rst_left > 0) begin
                m_rst_left--;
                if (m_rst_left == 0) begin m_wait = 0; m_streak = 0; end
            end else if (m_run) begin
                if (!lk) begin
                    m_run = 0; m_lost = 1; m_rst_left = R;
                    if (m_rl < 255) m_rl++;
                end
            end else if (m_streak > 0) begin
                if (!lk) begin m_streak = 0; m_wait = 0; end
                else if (m_streak == S) begin m_run = 1; m_streak = 0; end
                else m_streak++;
            end else begin
                if (lk) m_streak = 1;
                else begin
                    m_wait++;
                    if (m_wait == T) begin
                        if (m_to < 255) m_to++;
                        m_rst_left = R; m_wait = 0;
                    end
                end
            end
            m_sync = {m_sync[SS-2:0], locked};
        end
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge refclk);
    endtask

    task automatic apply_reset(input logic lk);
        @(negedge refclk);
        rst_n = 1'b0; locked = lk;
        wait_neg(3);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        @(negedge refclk);
        rst_n = 1'b0; locked = 1'b0;
        #2;
        checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL reset_pll_rst: got %b expected 1", pll_rst); end
        checks++; if (pll_ready !== 1'b0) begin errors++; $display("FAIL reset_pll_ready: got %b expected 0", pll_ready); end
        checks++; if (lock_lost !== 1'b0) begin errors++; $display("FAIL reset_lock_lost: got %b expected 0", lock_lost); end
        checks++; if (relock_count !== 8'd0) begin errors++; $display("FAIL reset_relock: got %0d expected 0", relock_count); end
        checks++; if (timeout_count !== 8'd0) begin errors++; $display("FAIL reset_timeout: got %0d expected 0", timeout_count); end
        $display("reset: pll_rst=%b pll_ready=%b", pll_rst, pll_ready);
        wait_neg(2);
    endtask

    task automatic test_powerup_lock;
        int n;
        apply_reset(1'b0);
        n = 0;
        do begin @(negedge refclk); n++; end while (pll_rst === 1'b1 && n < 100);
        checks++; if (n != R) begin errors++; $display("FAIL powerup_rst_width: got %0d expected %0d", n, R); end
        wait_neg(5);
        locked = 1'b1;
        n = 0;
        do begin @(negedge refclk); n++; end while (pll_ready !== 1'b1 && n < 100);
        checks++; if (n != SS + S + 1) begin errors++; $display("FAIL powerup_ready_latency: got %0d expected %0d", n, SS + S + 1); end
        checks++; if (relock_count !== 8'd0) begin errors++; $display("FAIL powerup_relock: got %0d expected 0", relock_count); end
        checks++; if (timeout_count !== 8'd0) begin errors++; $display("FAIL powerup_timeout: got %0d expected 0", timeout_count); end
        $display("powerup: rst_width ok path, ready latency=%0d", n);
    endtask

    task automatic test_timeout;
        int n, lo, hi;
        bit saw_ready;
        apply_reset(1'b0);
        saw_ready = 0;
        n = 0;
        do begin @(negedge refclk); n++; end while (pll_rst === 1'b1 && n < 100);
        for (int k = 1; k <= 3; k++) begin
            lo = 1;
            for (int g = 0; g < 100; g++) begin
                @(negedge refclk);
                if (pll_ready === 1'b1) saw_ready = 1;
                if (pll_rst === 1'b0) lo++; else break;
            end
            checks++; if (lo != T) begin errors++; $display("FAIL timeout_wait_len[%0d]: got %0d expected %0d", k, lo, T); end
            checks++; if (timeout_count !== 8'(k)) begin errors++; $display("FAIL timeout_count[%0d]: got %0d expected %0d", k, timeout_count, k); end
            hi = 1;
            for (int g = 0; g < 100; g++) begin
                @(negedge refclk);
                if (pll_rst === 1'b1) hi++; else break;
            end
            checks++; if (hi != R) begin errors++; $display("FAIL timeout_rst_width[%0d]: got %0d expected %0d", k, hi, R); end
            $display("timeout %0d: wait=%0d rst=%0d count=%0d", k, lo, hi, timeout_count);
        end
        checks++; if (saw_ready) begin errors++; $display("FAIL timeout_ready_stuck: got 1 expected 0"); end
    endtask

    task automatic test_lock_loss;
        int n, fall_at, lost_hi, rst_hi;
        apply_reset(1'b1);
        n = 0;
        do begin @(negedge refclk); n++; end while (pll_ready !== 1'b1 && n < 200);
        checks++; if (pll_ready !== 1'b1) begin errors++; $display("FAIL loss_reach_run: got %b expected 1", pll_ready); end
        locked = 1'b0;
        fall_at = -1; lost_hi = 0; rst_hi = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge refclk);
            if (fall_at < 0 && pll_ready === 1'b0) fall_at = k;
            if (lock_lost === 1'b1) lost_hi++;
            if (pll_rst === 1'b1) rst_hi++;
            if (k == 10) locked = 1'b1;
        end
        checks++; if (fall_at != SS + 1) begin errors++; $display("FAIL loss_ready_fall: got %0d expected %0d", fall_at, SS + 1); end
        checks++; if (lost_hi != 1) begin errors++; $display("FAIL loss_pulse_width: got %0d expected 1", lost_hi); end
        checks++; if (rst_hi != R) begin errors++; $display("FAIL loss_rst_width: got %0d expected %0d", rst_hi, R); end
        checks++; if (relock_count !== 8'd1) begin errors++; $display("FAIL loss_relock: got %0d expected 1", relock_count); end
        n = 0;
        do begin @(negedge refclk); n++; end while (pll_ready !== 1'b1 && n < 200);
        checks++; if (pll_ready !== 1'b1) begin errors++; $display("FAIL loss_requalify: got %b expected 1", pll_ready); end
        $display("lock loss: fall=%0d pulse=%0d rst=%0d relock=%0d", fall_at, lost_hi, rst_hi, relock_count);
    endtask

    task automatic test_stable_glitch;
        int n;
        apply_reset(1'b0);
        n = 0;
        do begin @(negedge refclk); n++; end while (pll_rst === 1'b1 && n < 100);
        wait_neg(2);
        locked = 1'b1;
        wait_neg(5);
        locked = 1'b0;
        wait_neg(3);
        locked = 1'b1;
        n = 0;
        do begin @(negedge refclk); n++; end while (pll_ready !== 1'b1 && n < 100);
        checks++; if (n != SS + S + 1) begin errors++; $display("FAIL glitch_requalify: got %0d expected %0d", n, SS + S + 1); end
        checks++; if (timeout_count !== 8'd0) begin errors++; $display("FAIL glitch_timeout: got %0d expected 0", timeout_count); end
        $display("stable glitch: ready %0d cycles after relock", n);
    endtask

    task automatic test_saturation;
        int n, exp_cnt;
        apply_reset(1'b1);
        for (int i = 1; i <= 300; i++) begin
            n = 0;
            do begin @(negedge refclk); n++; end while (pll_ready !== 1'b1 && n < 200);
            if (pll_ready !== 1'b1) begin
                errors++; checks++;
                $display("FAIL sat_reach_run[%0d]: got %b expected 1", i, pll_ready);
                return;
            end
            locked = 1'b0;
            n = 0;
            do begin @(negedge refclk); n++; end while (lock_lost !== 1'b1 && n < 10);
            locked = 1'b1;
            exp_cnt = (i < 255) ? i : 255;
            checks++; if (relock_count !== 8'(exp_cnt)) begin errors++; $display("FAIL sat_relock[%0d]: got %0d expected %0d", i, relock_count, exp_cnt); end
            if (i == 254 || i == 255 || i == 256 || i == 300) $display("saturation: loss %0d relock=%0d", i, relock_count);
        end
    endtask

    task automatic test_async_reset;
        int n;
        apply_reset(1'b1);
        n = 0;
        do begin @(negedge refclk); n++; end while (pll_ready !== 1'b1 && n < 200);
        locked = 1'b0;
        n = 0;
        do begin @(negedge refclk); n++; end while (lock_lost !== 1'b1 && n < 10);
        locked = 1'b1;
        n = 0;
        do begin @(negedge refclk); n++; end while (pll_ready !== 1'b1 && n < 200);
        checks++; if (relock_count !== 8'd1 || pll_ready !== 1'b1) begin errors++; $display("FAIL areset_setup: got relock=%0d ready=%b expected 1/1", relock_count, pll_ready); end
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (pll_ready !== 1'b0) begin errors++; $display("FAIL areset_ready: got %b expected 0", pll_ready); end
        checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL areset_pll_rst: got %b expected 1", pll_rst); end
        checks++; if (relock_count !== 8'd0) begin errors++; $display("FAIL areset_relock: got %0d expected 0", relock_count); end
        wait_neg(2);
        rst_n = 1'b1;
        n = 0;
        do begin @(negedge refclk); n++; end while (pll_rst === 1'b1 && n < 100);
        checks++; if (n != R) begin errors++; $display("FAIL areset_rst_width: got %0d expected %0d", n, R); end
        do begin @(negedge refclk); n++; end while (pll_ready !== 1'b1 && n < 200);
        checks++; if (n != R + 1 + S) begin errors++; $display("FAIL areset_ready_latency: got %0d expected %0d", n, R + 1 + S); end
        $display("async reset: restart to ready in %0d cycles", n);
    endtask

    task automatic test_random;
        int cyc, len, start_err;
        logic val;
        apply_reset(1'b0);
        cyc = 0;
        start_err = errors;
        while (cyc < 4000 && errors - start_err < 20) begin
            val = 1'($urandom_range(0, 1));
            len = val ? $urandom_range(1, 40) : $urandom_range(1, 30);
            for (int k = 0; k < len; k++) begin
                @(negedge refclk);
                cyc++;
                checks++; if (pll_rst !== (m_rst_left > 0)) begin errors++; $display("FAIL rand_pll_rst@%0d: got %b expected %b", cyc, pll_rst, (m_rst_left > 0)); end
                checks++; if (pll_ready !== m_run) begin errors++; $display("FAIL rand_pll_ready@%0d: got %b expected %b", cyc, pll_ready, m_run); end
                checks++; if (lock_lost !== m_lost) begin errors++; $display("FAIL rand_lock_lost@%0d: got %b expected %b", cyc, lock_lost, m_lost); end
                checks++; if (relock_count !== 8'(m_rl)) begin errors++; $display("FAIL rand_relock@%0d: got %0d expected %0d", cyc, relock_count, m_rl); end
                checks++; if (timeout_count !== 8'(m_to)) begin errors++; $display("FAIL rand_timeout@%0d: got %0d expected %0d", cyc, timeout_count, m_to); end
                if (k == 0) locked = val;
                if (cyc == 2000) rst_n = 1'b0;
                if (cyc == 2003) rst_n = 1'b1;
            end
        end
        $display("random: %0d cycles, relock=%0d timeout=%0d", cyc, relock_count, timeout_count);
    endtask

    initial begin
        test_reset();
        test_powerup_lock();
        test_timeout();
        test_lock_loss();
        test_stable_glitch();
        test_saturation();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
